// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control: state codes, opcodes,
// ALU operation codes, datapath mux selects and the packed control word.
package mc_pkg;

   localparam int OPW = 6;
   localparam int STW = 4;

   localparam logic [STW-1:0] S_FETCH  = 4'd0;
   localparam logic [STW-1:0] S_DECODE = 4'd1;
   localparam logic [STW-1:0] S_MEMADR = 4'd2;
   localparam logic [STW-1:0] S_MEMRD  = 4'd3;
   localparam logic [STW-1:0] S_MEMWB  = 4'd4;
   localparam logic [STW-1:0] S_MEMWR  = 4'd5;
   localparam logic [STW-1:0] S_RTEX   = 4'd6;
   localparam logic [STW-1:0] S_RTWB   = 4'd7;
   localparam logic [STW-1:0] S_BRANCH = 4'd8;
   localparam logic [STW-1:0] S_IMMEX  = 4'd9;
   localparam logic [STW-1:0] S_IMMWB  = 4'd10;
   localparam logic [STW-1:0] S_JUMP   = 4'd11;

   localparam logic [OPW-1:0] OP_RTYPE  = 6'b000000;
   localparam logic [OPW-1:0] OP_REGIMM = 6'b000001;
   localparam logic [OPW-1:0] OP_J      = 6'b000010;
   localparam logic [OPW-1:0] OP_BEQ    = 6'b000100;
   localparam logic [OPW-1:0] OP_BNE    = 6'b000101;
   localparam logic [OPW-1:0] OP_BLEZ   = 6'b000110;
   localparam logic [OPW-1:0] OP_BGTZ   = 6'b000111;
   localparam logic [OPW-1:0] OP_ADDI   = 6'b001000;
   localparam logic [OPW-1:0] OP_ANDI   = 6'b001100;
   localparam logic [OPW-1:0] OP_ORI    = 6'b001101;
   localparam logic [OPW-1:0] OP_LW     = 6'b100011;
   localparam logic [OPW-1:0] OP_SW     = 6'b101011;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_BR    = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_RTYPE = 4'b0110;
   localparam logic [3:0] ALU_BGEZ  = 4'b1001;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsource;
      logic [3:0] aluop;
      logic       illegal;
   } ctrl_t;

   // DECODE dispatch target; S_FETCH doubles as the "unsupported opcode" marker.
   function automatic logic [STW-1:0] dispatch(input logic [OPW-1:0] op);
      case (op)
         OP_LW, OP_SW:                                   return S_MEMADR;
         OP_RTYPE:                                       return S_RTEX;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM:    return S_BRANCH;
         OP_ADDI, OP_ANDI, OP_ORI:                       return S_IMMEX;
         OP_J:                                           return S_JUMP;
         default:                                        return S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control/datapath boundary of the main control FSM. master = controller side,
// slave = datapath side.
interface mc_control_if;
   import mc_pkg::*;

   logic [OPW-1:0] op;
   logic           rt0;
   logic           mem_ready;
   logic           pcwrite;
   logic           pcwritecond;
   logic           iord;
   logic           memread;
   logic           memwrite;
   logic           irwrite;
   logic           memtoreg;
   logic           regdst;
   logic           regwrite;
   logic           alusrca;
   logic [1:0]     alusrcb;
   logic [1:0]     pcsource;
   logic [3:0]     aluop;
   logic           illegal;
   logic [STW-1:0] state;

   modport master (
      input  op, rt0, mem_ready,
      output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
             memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
             aluop, illegal, state
   );

   modport slave (
      output op, rt0, mem_ready,
      input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
             memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
             aluop, illegal, state
   );

endinterface

// File: rtl/mc_out_decode.sv
// Moore output decoder: state (+op/rt0 for ALU selection, mem_ok for fetch
// load gating) to the packed control word. All-zero while reset is high.
module mc_out_decode
   import mc_pkg::*;
(
   input  logic           reset,
   input  logic [STW-1:0] state,
   input  logic [OPW-1:0] op,
   input  logic           rt0,
   input  logic           mem_ok,
   output ctrl_t          ctrl
);

   always_comb begin
      ctrl = '0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               ctrl.memread = 1'b1;
               ctrl.alusrcb = SRCB_FOUR;
               // IR and PC load only on the cycle the fetch actually completes
               ctrl.irwrite = mem_ok;
               ctrl.pcwrite = mem_ok;
            end
            S_DECODE: begin
               ctrl.alusrcb = SRCB_IMMSH;
               ctrl.illegal = (dispatch(op) == S_FETCH);
            end
            S_MEMADR: begin
               ctrl.alusrca = 1'b1;
               ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
               ctrl.memread = 1'b1;
               ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
               ctrl.regwrite = 1'b1;
               ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
               ctrl.memwrite = 1'b1;
               ctrl.iord     = 1'b1;
            end
            S_RTEX: begin
               ctrl.alusrca = 1'b1;
               ctrl.aluop   = ALU_RTYPE;
            end
            S_RTWB: begin
               ctrl.regwrite = 1'b1;
               ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
               ctrl.alusrca     = 1'b1;
               ctrl.pcsource    = PCSRC_ALUOUT;
               ctrl.pcwritecond = 1'b1;
               ctrl.aluop       = (op == OP_REGIMM && rt0) ? ALU_BGEZ : ALU_BR;
            end
            S_IMMEX: begin
               ctrl.alusrca = 1'b1;
               ctrl.alusrcb = SRCB_IMM;
               case (op)
                  OP_ANDI: ctrl.aluop = ALU_AND;
                  OP_ORI:  ctrl.aluop = ALU_OR;
                  default: ctrl.aluop = ALU_ADD;
               endcase
            end
            S_IMMWB: begin
               ctrl.regwrite = 1'b1;
            end
            S_JUMP: begin
               ctrl.pcwrite  = 1'b1;
               ctrl.pcsource = PCSRC_JUMP;
            end
            default: ctrl = '0;
         endcase
      end
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM. Optional MEM_WAIT_EN stalls FETCH/MEMRD/MEMWR
// until mem_ready; without it memory states always take one cycle.
module mc_control
   import mc_pkg::*;
#(
   parameter int OPW_P = OPW,
   parameter int STW_P = STW
) (
   input  logic         clk,
   input  logic         reset,
   mc_control_if.master bus
);

   logic [STW_P-1:0] state_q;
   logic [STW_P-1:0] state_d;
   logic [OPW_P-1:0] op;
   logic             mem_ok;
   ctrl_t            ctrl;

   assign op = bus.op;

`ifdef MEM_WAIT_EN
   assign mem_ok = bus.mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = bus.mem_ready;
   assign mem_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
         S_DECODE: state_d = dispatch(op);
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
         S_RTEX:   state_d = S_RTWB;
         S_IMMEX:  state_d = S_IMMWB;
         default:  state_d = S_FETCH;
      endcase
   end

   mc_out_decode u_out_decode (
      .reset  (reset),
      .state  (state_q),
      .op     (op),
      .rt0    (bus.rt0),
      .mem_ok (mem_ok),
      .ctrl   (ctrl)
   );

   always_comb begin
      bus.pcwrite     = ctrl.pcwrite;
      bus.pcwritecond = ctrl.pcwritecond;
      bus.iord        = ctrl.iord;
      bus.memread     = ctrl.memread;
      bus.memwrite    = ctrl.memwrite;
      bus.irwrite     = ctrl.irwrite;
      bus.memtoreg    = ctrl.memtoreg;
      bus.regdst      = ctrl.regdst;
      bus.regwrite    = ctrl.regwrite;
      bus.alusrca     = ctrl.alusrca;
      bus.alusrcb     = ctrl.alusrcb;
      bus.pcsource    = ctrl.pcsource;
      bus.aluop       = ctrl.aluop;
      bus.illegal     = ctrl.illegal;
      bus.state       = reset ? '0 : state_q;
   end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: table of instructions with explicit state walks, a
// per-cycle expected-word scoreboard, and hand sequences for reset and MEM_WAIT_EN stalls.
module tb_mc_control;
   import mc_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mc_control_if bus ();

   mc_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int    st;
      ctrl_t w;
   } exp_t;

   typedef struct {
      logic [5:0] op;
      logic       rt0;
      int         n;
      int         st[5];
      int         ill;
   } vec_t;

   exp_t exp_q[$];
   vec_t tbl[16];
   int   n_tbl = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ill_cnt = 0;

   // Expected control word written straight from the state/output table.
   function automatic ctrl_t exp_word(input int st, input logic [5:0] op,
                                      input logic rt0, input logic mr);
      ctrl_t w;
      logic  ok;
      w = '0;
`ifdef MEM_WAIT_EN
      ok = mr;
`else
      ok = 1'b1;
`endif
      case (st)
         0: begin w.memread = 1; w.irwrite = ok; w.pcwrite = ok; w.alusrcb = 2'b01; end
         1: begin
            w.alusrcb = 2'b11;
            w.illegal = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                     6'b000110, 6'b000111, 6'b000001, 6'b001000, 6'b001100,
                                     6'b001101, 6'b000010});
         end
         2:  begin w.alusrca = 1; w.alusrcb = 2'b10; end
         3:  begin w.memread = 1; w.iord = 1; end
         4:  begin w.regwrite = 1; w.memtoreg = 1; end
         5:  begin w.memwrite = 1; w.iord = 1; end
         6:  begin w.alusrca = 1; w.aluop = 4'b0110; end
         7:  begin w.regwrite = 1; w.regdst = 1; end
         8: begin
            w.alusrca = 1; w.pcsource = 2'b01; w.pcwritecond = 1;
            w.aluop = (op == 6'b000001 && rt0) ? 4'b1001 : 4'b0001;
         end
         9: begin
            w.alusrca = 1; w.alusrcb = 2'b10;
            w.aluop = (op == 6'b001100) ? 4'b0010 : (op == 6'b001101) ? 4'b0011 : 4'b0000;
         end
         10: w.regwrite = 1;
         11: begin w.pcwrite = 1; w.pcsource = 2'b10; end
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic ctrl_t act_word();
      ctrl_t w;
      w.pcwrite = bus.pcwrite;   w.pcwritecond = bus.pcwritecond;
      w.iord = bus.iord;         w.memread = bus.memread;
      w.memwrite = bus.memwrite; w.irwrite = bus.irwrite;
      w.memtoreg = bus.memtoreg; w.regdst = bus.regdst;
      w.regwrite = bus.regwrite; w.alusrca = bus.alusrca;
      w.alusrcb = bus.alusrcb;   w.pcsource = bus.pcsource;
      w.aluop = bus.aluop;       w.illegal = bus.illegal;
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   task automatic add_vec(input logic [5:0] op, input logic rt0, input int n,
                          input int s2, input int s3, input int s4, input int ill);
      tbl[n_tbl].op = op;   tbl[n_tbl].rt0 = rt0; tbl[n_tbl].n = n;
      tbl[n_tbl].st[0] = 0; tbl[n_tbl].st[1] = 1; tbl[n_tbl].st[2] = s2;
      tbl[n_tbl].st[3] = s3; tbl[n_tbl].st[4] = s4; tbl[n_tbl].ill = ill;
      n_tbl++;
   endtask

   // Called at a negedge in FETCH; leaves the bench at the negedge after the last cycle.
   task automatic run_seq(input string name, input logic [5:0] op, input logic rt0,
                          input int n, input int st[10], input logic mr[10]);
      exp_t e;
      ctrl_t a;
      for (int i = 0; i < n; i++) begin
         e.st = st[i];
         e.w  = exp_word(st[i], op, rt0, mr[i]);
         exp_q.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
         bus.op = op; bus.rt0 = rt0; bus.mem_ready = mr[i];
         #1;
         e = exp_q.pop_front();
         a = act_word();
         if (a.illegal) ill_cnt++;
         check({name, "/state"}, 32'(bus.state), 32'(e.st));
         check({name, "/ctrl"}, 32'(a), 32'(e.w));
         @(negedge clk);
      end
      $display("txn %s op=%b rt0=%b cycles=%0d", name, op, rt0, n);
   endtask

   initial begin
      int   st[10];
      logic mr[10];

      add_vec(6'b100011, 0, 5, 2, 3, 4, 0);   // lw
      add_vec(6'b101011, 0, 4, 2, 5, 0, 0);   // sw
      add_vec(6'b000000, 0, 4, 6, 7, 0, 0);   // R-type
      add_vec(6'b001000, 0, 4, 9, 10, 0, 0);  // addi
      add_vec(6'b001100, 0, 4, 9, 10, 0, 0);  // andi
      add_vec(6'b001101, 0, 4, 9, 10, 0, 0);  // ori
      add_vec(6'b000100, 0, 3, 8, 0, 0, 0);   // beq
      add_vec(6'b000101, 1, 3, 8, 0, 0, 0);   // bne (rt0 irrelevant)
      add_vec(6'b000110, 0, 3, 8, 0, 0, 0);   // blez
      add_vec(6'b000111, 0, 3, 8, 0, 0, 0);   // bgtz
      add_vec(6'b000001, 1, 3, 8, 0, 0, 0);   // bgez
      add_vec(6'b000001, 0, 3, 8, 0, 0, 0);   // bltz
      add_vec(6'b000010, 0, 3, 11, 0, 0, 0);  // j
      add_vec(6'b111111, 0, 2, 0, 0, 0, 1);   // illegal
      add_vec(6'b010000, 0, 2, 0, 0, 0, 1);   // illegal

      reset = 1'b1; bus.op = 6'b100011; bus.rt0 = 1'b0; bus.mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset/state", 32'(bus.state), 32'd0);
         check("reset/ctrl", 32'(act_word()), 32'd0);
      end
      reset = 1'b0;

      for (int v = 0; v < n_tbl; v++) begin
         for (int i = 0; i < 10; i++) begin
            st[i] = (i < 5) ? tbl[v].st[i] : 0;
            mr[i] = 1'b1;
         end
         ill_cnt = 0;
         run_seq($sformatf("vec%0d", v), tbl[v].op, tbl[v].rt0, tbl[v].n, st, mr);
         check($sformatf("vec%0d/illegal_cycles", v), 32'(ill_cnt), 32'(tbl[v].ill));
      end

      // Reset asserted while in MEMADR of a store: no memwrite may follow.
      bus.op = 6'b101011; bus.mem_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      check("rst_mid/pre_state", 32'(bus.state), 32'd2);
      reset = 1'b1;
      #1;
      check("rst_mid/ctrl_in_reset", 32'(act_word()), 32'd0);
      @(negedge clk);
      check("rst_mid/memwrite", 32'(bus.memwrite), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_mid/after_state", 32'(bus.state), 32'd0);
      check("rst_mid/after_memwrite", 32'(bus.memwrite), 32'd0);
      #1;
      for (int i = 0; i < 10; i++) begin st[i] = 0; mr[i] = 1'b1; end
      st[1] = 1; st[2] = 2; st[3] = 5;
      run_seq("rst_mid/sw", 6'b101011, 0, 4, st, mr);

      // mem_ready low: stalls with MEM_WAIT_EN, ignored otherwise.
      for (int i = 0; i < 10; i++) begin st[i] = 0; mr[i] = 1'b1; end
`ifdef MEM_WAIT_EN
      st = '{0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
      mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      run_seq("wait/lw", 6'b100011, 0, 9, st, mr);
      st = '{0, 1, 2, 5, 5, 0, 0, 0, 0, 0};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      run_seq("wait/sw", 6'b101011, 0, 5, st, mr);
`else
      st = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0};
      mr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      run_seq("nowait/lw", 6'b100011, 0, 5, st, mr);
      st = '{0, 1, 2, 5, 0, 0, 0, 0, 0, 0};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      run_seq("nowait/sw", 6'b101011, 0, 4, st, mr);
`endif
      check("final/state_fetch", 32'(bus.state), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
